// File: rtl/iob_wb_arbiter.sv
// iob_wb_arbiter: two IOb requesters share one registered Wishbone master port, round-robin on ties.
// Optional macro IOB_WB_ARB_TIMEOUT_EN ends a stalled bus cycle as an error after 2^TIMEOUT_W-1 cycles.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no bus cycle; picks a pending slot and launches the cycle
// S_BUS  | cyc/stb asserted, waiting for ack, error or timeout
// S_RESP | one-cycle ready/rdata/error pulse to the granted requester
module iob_wb_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int READ_BYTES = 4,
    parameter int TIMEOUT_W  = 8
) (
    input  logic                clk_i,
    input  logic                arst_i,

    input  logic                m0_valid_i,
    input  logic [ADDR_W-1:0]   m0_address_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic                m0_ready_o,
    output logic                m0_error_o,

    input  logic                m1_valid_i,
    input  logic [ADDR_W-1:0]   m1_address_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                m1_ready_o,
    output logic                m1_error_o,

    output logic [ADDR_W-1:0]   wb_addr_o,
    output logic [DATA_W-1:0]   wb_data_o,
    output logic [DATA_W/8-1:0] wb_select_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic                wb_ack_i,
    input  logic                wb_error_i,
    input  logic [DATA_W-1:0]   wb_data_i,

    output logic [1:0]          grant_o
);

    localparam int SEL_W = DATA_W / 8;

    if (TIMEOUT_W < 2 || DATA_W % 8 != 0 || ADDR_W < 2) begin : g_bad_param
        $error("iob_wb_arbiter: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_pend0;
    logic [ADDR_W-1:0] r_addr0;
    logic [DATA_W-1:0] r_wdata0;
    logic [SEL_W-1:0]  r_wstrb0;
    logic              r_pend1;
    logic [ADDR_W-1:0] r_addr1;
    logic [DATA_W-1:0] r_wdata1;
    logic [SEL_W-1:0]  r_wstrb1;

    logic              r_last_m0;
    logic [1:0]        r_grant;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic [SEL_W-1:0]  r_wb_sel;
    logic              r_wb_we;
    logic              r_wb_cyc;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_start;
    logic              w_end;
    logic              w_pick_m1;
    logic              w_timeout;
    logic              w_done0;
    logic              w_done1;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [SEL_W-1:0]  w_wstrb;
    logic [SEL_W-1:0]  w_rd_sel;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // On a tie, m1 wins only if m0 owned the previous cycle.
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_end     = 1'b0;
        w_pick_m1 = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend0 || r_pend1) begin
                    w_start   = 1'b1;
                    w_pick_m1 = r_pend1 && (!r_pend0 || r_last_m0);
                    w_next    = S_BUS;
                end
            end
            S_BUS: begin
                if (wb_ack_i || wb_error_i || w_timeout) begin
                    w_end  = 1'b1;
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_done0 = (r_state == S_RESP) && r_grant[0];
    assign w_done1 = (r_state == S_RESP) && r_grant[1];

    // A new valid takes priority over clearing, so a re-request during RESP is kept.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_pend0  <= 1'b0;
            r_addr0  <= '0;
            r_wdata0 <= '0;
            r_wstrb0 <= '0;
            r_pend1  <= 1'b0;
            r_addr1  <= '0;
            r_wdata1 <= '0;
            r_wstrb1 <= '0;
        end else begin
            if (m0_valid_i) begin
                r_pend0  <= 1'b1;
                r_addr0  <= m0_address_i;
                r_wdata0 <= m0_wdata_i;
                r_wstrb0 <= m0_wstrb_i;
            end else if (w_done0) begin
                r_pend0  <= 1'b0;
            end
            if (m1_valid_i) begin
                r_pend1  <= 1'b1;
                r_addr1  <= m1_address_i;
                r_wdata1 <= m1_wdata_i;
                r_wstrb1 <= m1_wstrb_i;
            end else if (w_done1) begin
                r_pend1  <= 1'b0;
            end
        end
    end

    assign w_addr  = w_pick_m1 ? r_addr1  : r_addr0;
    assign w_wdata = w_pick_m1 ? r_wdata1 : r_wdata0;
    assign w_wstrb = w_pick_m1 ? r_wstrb1 : r_wstrb0;

    // Read mask: READ_BYTES ones starting at the byte offset, bits past SEL_W dropped.
    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < SEL_W; i++) begin
            w_rd_sel[i] = (i >= int'(w_addr[1:0])) &&
                          (i < int'(w_addr[1:0]) + READ_BYTES);
        end
    end

`ifdef IOB_WB_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMR_LOAD = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] r_tmr;

    // Loaded with 2^W-2 so terminal count lands on the (2^W-1)th BUS cycle.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_tmr <= '0;
        end else if (w_start) begin
            r_tmr <= TMR_LOAD;
        end else if (r_state == S_BUS && r_tmr != '0) begin
            r_tmr <= r_tmr - 1'b1;
        end
    end

    assign w_timeout = (r_state == S_BUS) && (r_tmr == '0);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_last_m0 <= 1'b0;
            r_grant   <= '0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_wb_sel  <= '0;
            r_wb_we   <= 1'b0;
            r_wb_cyc  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_start) begin
                r_grant   <= w_pick_m1 ? 2'b10 : 2'b01;
                r_last_m0 <= !w_pick_m1;
                r_wb_addr <= w_addr;
                r_wb_data <= w_wdata;
                r_wb_we   <= |w_wstrb;
                r_wb_sel  <= (|w_wstrb) ? w_wstrb : w_rd_sel;
                r_wb_cyc  <= 1'b1;
            end
            if (w_end) begin
                r_wb_cyc <= 1'b0;
                // An ack landing on the terminal-count cycle still counts as a success.
                if (wb_ack_i || wb_error_i) begin
                    r_rdata <= wb_data_i;
                    r_err   <= wb_error_i;
                end else begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
            if (r_state == S_RESP) begin
                r_grant <= '0;
            end
        end
    end

    assign wb_addr_o   = r_wb_addr;
    assign wb_data_o   = r_wb_data;
    assign wb_select_o = r_wb_sel;
    assign wb_we_o     = r_wb_we;
    assign wb_cyc_o    = r_wb_cyc;
    assign wb_stb_o    = r_wb_cyc;
    assign grant_o     = r_grant;

    assign m0_ready_o = w_done0;
    assign m0_error_o = w_done0 && r_err;
    assign m0_rdata_o = w_done0 ? r_rdata : '0;
    assign m1_ready_o = w_done1;
    assign m1_error_o = w_done1 && r_err;
    assign m1_rdata_o = w_done1 ? r_rdata : '0;

endmodule

// File: tb/tb_iob_wb_arbiter.sv
// Directed bench for iob_wb_arbiter: read, latency, ack+error, write error, round-robin,
// re-request in RESP, mid-cycle reset and bus timeout (IOB_WB_ARB_TIMEOUT_EN) or indefinite wait.
module tb_iob_wb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TW = 4;

    logic          clk_i = 1'b0;
    logic          arst_i = 1'b1;
    logic          m0_valid_i = 1'b0;
    logic [AW-1:0] m0_address_i = '0;
    logic [DW-1:0] m0_wdata_i = '0;
    logic [SW-1:0] m0_wstrb_i = '0;
    logic [DW-1:0] m0_rdata_o;
    logic          m0_ready_o;
    logic          m0_error_o;
    logic          m1_valid_i = 1'b0;
    logic [AW-1:0] m1_address_i = '0;
    logic [DW-1:0] m1_wdata_i = '0;
    logic [SW-1:0] m1_wstrb_i = '0;
    logic [DW-1:0] m1_rdata_o;
    logic          m1_ready_o;
    logic          m1_error_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_data_o;
    logic [SW-1:0] wb_select_o;
    logic          wb_we_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_ack_i = 1'b0;
    logic          wb_error_i = 1'b0;
    logic [DW-1:0] wb_data_i = '0;
    logic [1:0]    grant_o;

    int checks = 0;
    int failures = 0;

    iob_wb_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .READ_BYTES(4), .TIMEOUT_W(TW)
    ) dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .m0_valid_i(m0_valid_i), .m0_address_i(m0_address_i), .m0_wdata_i(m0_wdata_i),
        .m0_wstrb_i(m0_wstrb_i), .m0_rdata_o(m0_rdata_o), .m0_ready_o(m0_ready_o),
        .m0_error_o(m0_error_o),
        .m1_valid_i(m1_valid_i), .m1_address_i(m1_address_i), .m1_wdata_i(m1_wdata_i),
        .m1_wstrb_i(m1_wstrb_i), .m1_rdata_o(m1_rdata_o), .m1_ready_o(m1_ready_o),
        .m1_error_o(m1_error_o),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_select_o(wb_select_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .wb_error_i(wb_error_i), .wb_data_i(wb_data_i),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        m0_valid_i = 1'b1; m0_address_i = a; m0_wdata_i = d; m0_wstrb_i = s;
    endtask

    task automatic req1(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        m1_valid_i = 1'b1; m1_address_i = a; m1_wdata_i = d; m1_wstrb_i = s;
    endtask

    task automatic quiet();
        m0_valid_i = 1'b0; m1_valid_i = 1'b0; wb_ack_i = 1'b0; wb_error_i = 1'b0;
    endtask

    task automatic wait_cyc(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (wb_cyc_o) break;
            step();
        end
        chk(tag, wb_cyc_o, 1);
    endtask

    initial begin
        logic [1:0] exp_grant [4];
        int n;
        int rdy_cnt;
        int cyc_cnt;
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;

        // reset state
        #1;
        chk("rst_grant", grant_o, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_sel", wb_select_o, 0);
        chk("rst_addr", wb_addr_o, 0);
        chk("rst_ready", {m0_ready_o, m1_ready_o, m0_error_o, m1_error_o}, 0);
        step(); step();
        arst_i = 1'b0;
        step();

        // m0 read at 0x102, ack on the third BUS cycle
        req0(32'h102, 32'h0, 4'h0);
        step(); quiet();
        chk("rd_cyc_c1", wb_cyc_o, 0);
        step();
        chk("rd_cyc_c2", wb_cyc_o, 1);
        chk("rd_stb_c2", wb_stb_o, 1);
        chk("rd_grant", grant_o, 2'b01);
        chk("rd_sel", wb_select_o, 4'b1100);
        chk("rd_we", wb_we_o, 0);
        chk("rd_addr", wb_addr_o, 32'h102);
        step();
        chk("rd_noready_b2", m0_ready_o, 0);
        step();
        wb_ack_i = 1'b1; wb_data_i = 32'hCAFEF00D;
        step(); quiet();
        chk("rd_ready", m0_ready_o, 1);
        chk("rd_rdata", m0_rdata_o, 32'hCAFEF00D);
        chk("rd_error", m0_error_o, 0);
        chk("rd_m1_quiet", {m1_ready_o, m1_error_o, m1_rdata_o}, 0);
        chk("rd_cyc_drop", wb_cyc_o, 0);
        step();
        chk("rd_ready_once", m0_ready_o, 0);
        chk("rd_grant_idle", grant_o, 0);

        // m1 read at 0x0, minimum latency
        req1(32'h0, 32'h0, 4'h0);
        step(); quiet();
        step();
        chk("lat_cyc_c2", wb_cyc_o, 1);
        chk("lat_grant", grant_o, 2'b10);
        chk("lat_sel", wb_select_o, 4'b1111);
        wb_ack_i = 1'b1; wb_data_i = 32'h11223344;
        step(); quiet();
        chk("lat_ready_c3", m1_ready_o, 1);
        chk("lat_rdata", m1_rdata_o, 32'h11223344);
        chk("lat_m0_quiet", {m0_ready_o, m0_rdata_o}, 0);
        step();

        // ack and error together report an error
        req0(32'h4, 32'h0, 4'h0);
        step(); quiet();
        step();
        wb_ack_i = 1'b1; wb_error_i = 1'b1; wb_data_i = 32'h55;
        step(); quiet();
        chk("both_ready", m0_ready_o, 1);
        chk("both_error", m0_error_o, 1);
        step();

        // m1 write, bus error
        req1(32'h40, 32'h1234, 4'h3);
        step(); quiet();
        step();
        chk("wr_we", wb_we_o, 1);
        chk("wr_sel", wb_select_o, 4'h3);
        chk("wr_data", wb_data_o, 32'h1234);
        chk("wr_grant", grant_o, 2'b10);
        wb_error_i = 1'b1;
        step(); quiet();
        chk("wr_ready", m1_ready_o, 1);
        chk("wr_error", m1_error_o, 1);
        chk("wr_m0_quiet", {m0_ready_o, m0_error_o}, 0);
        step();

        // simultaneous requests, twice; last grant was m1 so m0 leads
        for (int p = 0; p < 2; p++) begin
            req0(32'h100 + p, 32'h0, 4'h0);
            req1(32'h200 + p, 32'h0, 4'h0);
            step(); quiet();
            for (int k = 0; k < 2; k++) begin
                wait_cyc("rr_cyc_wait");
                chk("rr_grant", grant_o, exp_grant[2*p+k]);
                wb_ack_i = 1'b1; wb_data_i = 32'hA000 + 32'(2*p+k);
                step(); quiet();
                chk("rr_rdy0", m0_ready_o, exp_grant[2*p+k][0]);
                chk("rr_rdy1", m1_ready_o, exp_grant[2*p+k][1]);
                chk("rr_rdata", m0_rdata_o | m1_rdata_o, 32'hA000 + 32'(2*p+k));
                step();
            end
        end

        // re-request from m0 while its previous access is in RESP
        req0(32'h10, 32'h0, 4'h0);
        step(); quiet();
        step();
        wb_ack_i = 1'b1; wb_data_i = 32'h77;
        step(); quiet();
        chk("rereq_resp", m0_ready_o, 1);
        req0(32'h300, 32'hAA, 4'hF);
        step(); quiet();
        step();
        chk("rereq_cyc", wb_cyc_o, 1);
        chk("rereq_addr", wb_addr_o, 32'h300);
        chk("rereq_we", wb_we_o, 1);
        chk("rereq_grant", grant_o, 2'b01);
        wb_ack_i = 1'b1;
        step(); quiet();
        chk("rereq_ready", m0_ready_o, 1);
        step();

        // reset during BUS
        req1(32'h20, 32'h0, 4'h0);
        step(); quiet();
        step();
        chk("mrst_pre_cyc", wb_cyc_o, 1);
        #1 arst_i = 1'b1;
        #1;
        chk("mrst_cyc", wb_cyc_o, 0);
        chk("mrst_stb", wb_stb_o, 0);
        chk("mrst_grant", grant_o, 0);
        step(); step();
        arst_i = 1'b0;
        rdy_cnt = 0; cyc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            rdy_cnt += int'(m0_ready_o) + int'(m1_ready_o);
            cyc_cnt += int'(wb_cyc_o);
        end
        chk("mrst_no_ready", rdy_cnt, 0);
        chk("mrst_idle", cyc_cnt, 0);

        // stalled slave: timeout when enabled, indefinite wait otherwise
        req0(32'h8, 32'h0, 4'h0);
        wb_data_i = 32'hDEADBEEF;
        step(); quiet();
        step();
        chk("to_cyc_start", wb_cyc_o, 1);
`ifdef IOB_WB_ARB_TIMEOUT_EN
        n = 0;
        while (wb_cyc_o && n < 40) begin
            n++;
            step();
        end
        chk("to_cycles", n, 15);
        chk("to_ready", m0_ready_o, 1);
        chk("to_error", m0_error_o, 1);
        chk("to_rdata", m0_rdata_o, 0);
        step();
`else
        n = 0;
        repeat (100) step();
        chk("nto_cyc_held", wb_cyc_o, 1);
        chk("nto_no_ready", m0_ready_o, 0);
        wb_ack_i = 1'b1;
        step(); quiet();
        chk("nto_ready", m0_ready_o, 1);
        chk("nto_rdata", m0_rdata_o, 32'hDEADBEEF);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
